// File: rtl/cpu_pkg.sv
// Shared CPU types: bus opcodes and the bus front-end state encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_IF    = 3'd1,
    BUS_IF_CB = 3'd2,
    BUS_READ  = 3'd3,
    BUS_WRITE = 3'd4
  } bus_opcode_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_t;

endpackage

// File: rtl/cpu_bus_unit_perf.sv
// Free-running cycle counter and stall-cycle counter, both wrapping.
module bus_perf_counters #(
  parameter int unsigned CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Count every non-reset cycle, and every cycle the core is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (stall_i) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/cpu_bus_unit.sv
// Bus front-end: req/ready handshake with wait states, core stall,
// timeout abort, registered fetch/read data and performance counters.
module cpu_bus_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W  = 16,
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      TIMEOUT = 255,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(8'hFF),
  parameter int unsigned      CNT_W   = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_opcode_t       bus_op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall,
  output logic              op_done,
  output logic              bus_err,
  output logic [7:0]        opcode,
  output logic [7:0]        cb_opcode,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  bus_state_t        state_q;
  bus_opcode_t       hold_op_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_wdata_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              op_done_q;
  logic              bus_err_q;
  logic [7:0]        opcode_q;
  logic [7:0]        cb_opcode_q;
  logic [DATA_W-1:0] rdata_q;

  bus_opcode_t       cur_op_c;
  logic              active_c;
  logic              complete_c;
  logic              abort_c;
  logic              tmo_hit_c;
  logic [DATA_W-1:0] rd_val_c;

  assign tmo_hit_c = (TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TMO_LAST));

  // Select the live request (IDLE) or the held one (WAIT) and drive the bus.
  always_comb begin
    cur_op_c  = hold_op_q;
    mem_addr  = hold_addr_q;
    mem_wdata = hold_wdata_q;
    if (state_q == IDLE) begin
      cur_op_c  = bus_op;
      mem_addr  = addr_in;
      mem_wdata = wdata_in;
    end
    active_c   = !rst && (cur_op_c != BUS_NONE);
    complete_c = active_c && mem_ready;
    abort_c    = active_c && (state_q == WAIT) && !mem_ready && tmo_hit_c;
    rd_val_c   = complete_c ? mem_rdata : FILL;
    mem_req    = active_c;
    mem_we     = active_c && (cur_op_c == BUS_WRITE);
    stall      = active_c && !mem_ready && !abort_c;
  end

  // State, holding registers, timeout counter and latched results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_op_q    <= BUS_NONE;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      tmo_cnt_q    <= '0;
      op_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      opcode_q     <= '0;
      cb_opcode_q  <= '0;
      rdata_q      <= '0;
    end else begin
      op_done_q <= complete_c || abort_c;
      if (abort_c) bus_err_q <= 1'b1;

      if (complete_c || abort_c) begin
        case (cur_op_c)
          BUS_IF:    opcode_q    <= 8'(rd_val_c);
          BUS_IF_CB: cb_opcode_q <= 8'(rd_val_c);
          BUS_READ:  rdata_q     <= rd_val_c;
          default:   ;
        endcase
      end

      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (active_c) begin
            hold_op_q    <= bus_op;
            hold_addr_q  <= addr_in;
            hold_wdata_q <= wdata_in;
            if (!mem_ready) state_q <= WAIT;
          end
        end
        WAIT: begin
          if (complete_c || abort_c) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_done   = op_done_q;
  assign bus_err   = bus_err_q;
  assign opcode    = opcode_q;
  assign cb_opcode = cb_opcode_q;
  assign rdata     = rdata_q;

  bus_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .cycle_cnt_o (cycle_cnt),
    .stall_cnt_o (stall_cnt)
  );

endmodule
